// File: rtl/decode_pkg.sv
// Shared constants and the ID/EX payload type for the pipelined MIPS decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_W   = 16;

    // Payload fields are sized for the widest supported build; narrower builds zero-pad.
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_AW     = 8;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rd_data1;
        logic [MAX_DATA_W-1:0] rd_data2;
        logic [MAX_DATA_W-1:0] imm_ext;
        logic [MAX_AW-1:0]     wr_addr;
        logic [INSTR_W-1:0]    instr;
    } id_ex_t;

endpackage

// File: rtl/pipelined_decode_reg_file.sv
// Two-read/one-write register file with hardwired zero register and optional WB forwarding.
module reg_file_bypass #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_CNT   = 32,
    parameter bit          BYPASS_EN = 1'b1,
    localparam int unsigned AW       = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] mem_q [REG_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = mem_q[rd_addr1];
        rd_data2 = mem_q[rd_addr2];
        if (BYPASS_EN && wr_en && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (BYPASS_EN && wr_en && (wr_addr == rd_addr2)) rd_data2 = wr_data;
        // Index 0 wins over forwarding so a WB to r0 never leaks through.
        if (rd_addr1 == '0) rd_data1 = '0;
        if (rd_addr2 == '0) rd_data2 = '0;
    end

endmodule

// File: rtl/pipelined_decode.sv
// Registered MIPS ID stage: register read, immediate extension, load-use stall and ID/EX handshake.
module pipelined_decode
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_CNT   = 32,
    parameter bit          BYPASS_EN = 1'b1,
    localparam int unsigned AW       = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic              reg_dst,
    input  logic              ext_zero,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] imm_ext,
    output logic [AW-1:0]     wr_addr,
    output logic [31:0]       out_instr
);

    logic [AW-1:0]     rs_idx, rt_idx, rd_idx, wr_sel;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, imm_val;
    logic              imm_sign, ld_stall, fire_in, fire_out;

    id_ex_t        id_ex_q, id_ex_d;
    logic          out_valid_q, out_valid_d;
    logic          ld_pend_q, ld_pend_d;
    logic [AW-1:0] ld_rt_q, ld_rt_d;
    logic          unused_id_ex;

    assign rs_idx   = instruction[RS_LSB +: AW];
    assign rt_idx   = instruction[RT_LSB +: AW];
    assign rd_idx   = instruction[RD_LSB +: AW];
    assign wr_sel   = reg_dst ? rd_idx : rt_idx;
    assign imm_sign = instruction[IMM_W-1] & ~ext_zero;

    if (DATA_W > IMM_W) begin : g_imm_wide
        assign imm_val = {{(DATA_W - IMM_W){imm_sign}}, instruction[IMM_W-1:0]};
    end else begin : g_imm_narrow
        assign imm_val = instruction[DATA_W-1:0];
    end

    reg_file_bypass #(
        .DATA_W    (DATA_W),
        .REG_CNT   (REG_CNT),
        .BYPASS_EN (BYPASS_EN)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr1 (rs_idx),
        .rd_data1 (rf_rd1),
        .rd_addr2 (rt_idx),
        .rd_data2 (rf_rd2)
    );

    // Stall term excludes in_valid so in_ready never depends on it; fire_in masks it anyway.
    assign ld_stall = ld_pend_q & (ld_rt_q != '0) & ((ld_rt_q == rs_idx) | (ld_rt_q == rt_idx));
    assign in_ready = (~out_valid_q | out_ready) & ~ld_stall & ~flush;
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        id_ex_d     = id_ex_q;
        ld_pend_d   = 1'b0;
        ld_rt_d     = ld_rt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else begin
            if (fire_out && (id_ex_q.instr[OP_LSB +: 6] == OP_LW)) begin
                ld_pend_d = 1'b1;
                ld_rt_d   = id_ex_q.instr[RT_LSB +: AW];
            end
            if (fire_in) begin
                out_valid_d      = 1'b1;
                id_ex_d.rd_data1 = MAX_DATA_W'(rf_rd1);
                id_ex_d.rd_data2 = MAX_DATA_W'(rf_rd2);
                id_ex_d.imm_ext  = MAX_DATA_W'(imm_val);
                id_ex_d.wr_addr  = MAX_AW'(wr_sel);
                id_ex_d.instr    = instruction;
            end else if (fire_out) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            id_ex_q     <= '0;
            ld_pend_q   <= 1'b0;
            ld_rt_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            id_ex_q     <= id_ex_d;
            ld_pend_q   <= ld_pend_d;
            ld_rt_q     <= ld_rt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign rd_data1     = id_ex_q.rd_data1[DATA_W-1:0];
    assign rd_data2     = id_ex_q.rd_data2[DATA_W-1:0];
    assign imm_ext      = id_ex_q.imm_ext[DATA_W-1:0];
    assign wr_addr      = id_ex_q.wr_addr[AW-1:0];
    assign out_instr    = id_ex_q.instr;
    assign unused_id_ex = ^id_ex_q;

endmodule
